// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage indices, default source depths, FSM states and thermometer helper for pipe_ctrl.
package pipe_ctrl_pkg;
  localparam int STG_PC = 0;
  localparam int STG_ID = 1;
  localparam int STG_RR = 2;
  localparam int STG_EX = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB = 5;
  localparam logic [11:0] SRC_DEPTH_DEF = {3'd2, 3'd5, 3'd3, 3'd2};
  typedef enum logic {IDLE, PEND} state_t;
  function automatic logic [31:0] therm(input logic [31:0] d);
    return d >= 32'd32 ? '1 : (32'd1 << d) - 32'd1;
  endfunction
endpackage

// File: rtl/pipe_ctrl_therm_dec.sv
// therm_dec: depth to thermometer decoder, bits 0..d-1 set.
module therm_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 6,
  parameter int DW = 3
) (
  input  logic [DW-1:0]     d,
  output logic [STAGES-1:0] t
);
  assign t = STAGES'(therm(32'(d)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with pending-flush buffering and perf counters.
// Optional stall watchdog enabled by defining PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 6,
  parameter int NSRC = 4,
  parameter int DW = $clog2(STAGES + 1),
  parameter logic [NSRC*DW-1:0] SRC_DEPTH = SRC_DEPTH_DEF,
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic [NSRC-1:0]   stall_req_in,
  input  logic              flush_req_in,
  input  logic [DW-1:0]     flush_depth_in,
  output logic [STAGES-1:0] stall_out,
  output logic [STAGES-1:0] flush_out,
  output logic              flush_busy_out,
  output logic [CNT_W-1:0]  stall_cnt_out,
  output logic [CNT_W-1:0]  flush_cnt_out,
  output logic              timeout_out
);
  state_t state_q, state_d;
  logic [DW-1:0] pend_q, pend_d, req_d, fd;
  logic [STAGES-1:0] src_t [NSRC];
  logic [STAGES-1:0] stall_raw, fl_t;
  logic held, apply;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    therm_dec #(.STAGES(STAGES), .DW(DW)) u_src (.d(SRC_DEPTH[i*DW +: DW]), .t(src_t[i]));
  end
  therm_dec #(.STAGES(STAGES), .DW(DW)) u_fl (.d(fd), .t(fl_t));
  always_comb begin
    stall_raw = '0;
    for (int k = 0; k < NSRC; k++) stall_raw = stall_raw | (stall_req_in[k] ? src_t[k] : '0);
  end
  // pend_q is zero in IDLE, so the max below also covers the no-pending case
  assign req_d = flush_req_in ? flush_depth_in : '0;
  assign fd = pend_q > req_d ? pend_q : req_d;
  assign held = |(stall_raw & (STAGES'(1) << fd));
  assign apply = rst_n_in && rdy_in && fd != '0 && !held;
  assign stall_out = !rst_n_in ? '1 : apply ? stall_raw & ~fl_t : rdy_in ? stall_raw : '1;
  assign flush_out = apply ? fl_t : '0;
  assign flush_busy_out = state_q == PEND;
  always_comb begin
    state_d = (apply || fd == '0) ? IDLE : PEND;
    pend_d = apply ? '0 : fd;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      pend_q <= '0;
      stall_cnt_out <= '0;
      flush_cnt_out <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      if (rdy_in && stall_out[0]) stall_cnt_out <= stall_cnt_out + CNT_W'(1);
      if (apply) flush_cnt_out <= flush_cnt_out + CNT_W'(1);
    end
  end
`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic to_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (rdy_in) begin
      wd_q <= !stall_out[0] ? '0 : wd_q == WW'(TIMEOUT) ? wd_q : wd_q + WW'(1);
      if (stall_out[0] && wd_q >= WW'(TIMEOUT - 1)) to_q <= 1'b1;
    end
  end
  assign timeout_out = to_q;
`else
  assign timeout_out = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in = 1'b1;
  logic [3:0] stall_req_in = '0;
  logic flush_req_in = 1'b0;
  logic [2:0] flush_depth_in = '0;
  logic [5:0] stall_out, flush_out;
  logic flush_busy_out, timeout_out;
  logic [31:0] stall_cnt_out, flush_cnt_out;
  typedef struct {
    int id;
    logic [5:0] st;
    logic [5:0] fl;
    logic b;
    logic to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  pipe_ctrl #(.TIMEOUT(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .stall_req_in(stall_req_in),
    .flush_req_in(flush_req_in), .flush_depth_in(flush_depth_in), .stall_out(stall_out),
    .flush_out(flush_out), .flush_busy_out(flush_busy_out), .stall_cnt_out(stall_cnt_out),
    .flush_cnt_out(flush_cnt_out), .timeout_out(timeout_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask
  task automatic cyc(input int id, input logic rst, input logic rdy, input logic [3:0] req,
                     input logic fr, input logic [2:0] fdp, input logic [5:0] st,
                     input logic [5:0] fl, input logic b, input int sc, input int fc,
                     input logic to);
    @(posedge clk_in);
    #1;
    rst_n_in = rst;
    rdy_in = rdy;
    stall_req_in = req;
    flush_req_in = fr;
    flush_depth_in = fdp;
    q.push_back('{id, st, fl, b, to, 32'(sc), 32'(fc)});
  endtask
  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_out", e.id, 32'(stall_out), 32'(e.st));
      chk("flush_out", e.id, 32'(flush_out), 32'(e.fl));
      chk("flush_busy", e.id, 32'(flush_busy_out), 32'(e.b));
      chk("stall_cnt", e.id, stall_cnt_out, e.sc);
      chk("flush_cnt", e.id, flush_cnt_out, e.fc);
      chk("timeout", e.id, 32'(timeout_out), 32'(e.to));
    end
  end
  initial begin
    //   id rst rdy req    fr fdp  stall   flush   b sc fc to
    cyc(0,  0, 1, 4'b0100, 0, 0, 6'h3F, 6'h00, 0, 0, 0, 0);
    cyc(1,  1, 1, 4'b1001, 0, 0, 6'h03, 6'h00, 0, 0, 0, 0);
    cyc(2,  1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 0, 1, 0, 0);
    cyc(3,  1, 1, 4'b0101, 0, 0, 6'h1F, 6'h00, 0, 2, 0, 0);
    cyc(4,  1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 3, 0, 0);
    cyc(5,  1, 1, 4'b0000, 1, 2, 6'h00, 6'h03, 0, 3, 0, 0);
    cyc(6,  1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 3, 1, 0);
    cyc(7,  1, 1, 4'b0100, 1, 3, 6'h1F, 6'h00, 0, 3, 1, 0);
    cyc(8,  1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 1, 4, 1, 0);
    cyc(9,  1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 1, 5, 1, 0);
    cyc(10, 1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 1, 6, 1, 0);
    cyc(11, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h07, 1, 7, 1, 0);
    cyc(12, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 7, 2, 0);
    cyc(13, 1, 1, 4'b0100, 1, 2, 6'h1F, 6'h00, 0, 7, 2, 0);
    cyc(14, 1, 1, 4'b0100, 1, 4, 6'h1F, 6'h00, 1, 8, 2, 0);
    cyc(15, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h0F, 1, 9, 2, 0);
    cyc(16, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 9, 3, 0);
    cyc(17, 1, 0, 4'b0000, 1, 2, 6'h3F, 6'h00, 0, 9, 3, 0);
    cyc(18, 1, 0, 4'b0000, 0, 0, 6'h3F, 6'h00, 1, 9, 3, 0);
    cyc(19, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h03, 1, 9, 3, 0);
    cyc(20, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 9, 4, 0);
    cyc(21, 1, 1, 4'b0100, 1, 3, 6'h1F, 6'h00, 0, 9, 4, 0);
    cyc(22, 1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 1, 10, 4, 0);
    cyc(23, 0, 1, 4'b0000, 0, 0, 6'h3F, 6'h00, 0, 0, 0, 0);
    cyc(24, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 0, 0, 0);
    cyc(25, 1, 1, 4'b0100, 1, 6, 6'h00, 6'h3F, 0, 0, 0, 0);
    cyc(26, 1, 1, 4'b0000, 1, 0, 6'h00, 6'h00, 0, 0, 1, 0);
    cyc(27, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(28 + i, 1, 1, 4'b0100, 0, 0, 6'h1F, 6'h00, 0, i, 1, 0);
    cyc(36, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 8, 1, WD);
    cyc(37, 1, 1, 4'b0000, 0, 0, 6'h00, 6'h00, 0, 8, 1, WD);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_in);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
